// File: rtl/ras_ctrl.sv
// Return-address stack controller.
// Turns decoded call/return events into push/pop strobes for an external
// stack, registers the predicted return target, drains the stack on flush
// and keeps saturating overflow/underflow statistics.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RUN   | normal operation, call/ret events drive the stack
// ST_DRAIN | flush in progress, one pop per cycle until the stack is empty
module ras_ctrl #(
  parameter int DW   = 32,
  parameter int ILEN = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            i_call,
  input  logic [DW-1:0]   i_call_pc,
  input  logic            i_ret,
  input  logic            i_flush,
  output logic            o_push_en,
  output logic [DW-1:0]   o_push_data,
  output logic            o_pop_en,
  input  logic [DW-1:0]   i_stk_pop_data,
  input  logic            i_stk_full,
  input  logic            i_stk_empty,
  output logic            o_pred_valid,
  output logic [DW-1:0]   o_pred_addr,
  output logic            o_busy,
  output logic [CNTW-1:0] o_ovf_cnt,
  output logic [CNTW-1:0] o_unf_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_push_en;
  logic            w_pop_en;
  logic            w_pred_load;
  logic            w_ovf_inc;
  logic            w_unf_inc;
  logic            r_pred_valid;
  logic [DW-1:0]   r_pred_addr;
  logic [CNTW-1:0] r_ovf_cnt;
  logic [CNTW-1:0] r_unf_cnt;

  // State register; reset aborts any drain in progress.
  always_ff @(posedge clk) begin
    if (!aresetn) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  // Next-state and stack strobe decode. Flush wins over call/ret in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_push_en   = 1'b0;
    w_pop_en    = 1'b0;
    w_pred_load = 1'b0;
    w_ovf_inc   = 1'b0;
    w_unf_inc   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_flush) begin
          w_state_nxt = ST_DRAIN;
        end else if (i_call && i_ret) begin
          // Coroutine swap: push+pop together replaces the top entry.
          w_push_en = 1'b1;
          if (!i_stk_empty) begin
            w_pop_en    = 1'b1;
            w_pred_load = 1'b1;
          end else begin
            w_unf_inc = 1'b1;
          end
        end else if (i_call) begin
          w_push_en = 1'b1;
          w_ovf_inc = i_stk_full;
        end else if (i_ret) begin
          if (!i_stk_empty) begin
            w_pop_en    = 1'b1;
            w_pred_load = 1'b1;
          end else begin
            w_unf_inc = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (i_stk_empty) w_state_nxt = ST_RUN;
        else             w_pop_en    = 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Prediction register: one-cycle valid pulse, address holds between pulses.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_pred_valid <= 1'b0;
      r_pred_addr  <= '0;
    end else begin
      r_pred_valid <= w_pred_load;
      if (w_pred_load) r_pred_addr <= i_stk_pop_data;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      if (w_ovf_inc && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      if (w_unf_inc && (r_unf_cnt != '1)) r_unf_cnt <= r_unf_cnt + 1'b1;
    end
  end

  // Strobes are held off while reset is asserted so the stack is untouched.
  assign o_push_en    = w_push_en & aresetn;
  assign o_pop_en     = w_pop_en & aresetn;
  assign o_push_data  = i_call_pc + DW'(ILEN);
  assign o_pred_valid = r_pred_valid;
  assign o_pred_addr  = r_pred_addr;
  assign o_busy       = (r_state == ST_DRAIN);
  assign o_ovf_cnt    = r_ovf_cnt;
  assign o_unf_cnt    = r_unf_cnt;

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: behavioural stack environment plus a queue-based
// reference model of call/return/flush semantics.
module tb_ras_ctrl;
  localparam int DW  = 32;
  localparam int DPT = 8;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          i_call = 1'b0;
  logic [DW-1:0] i_call_pc = '0;
  logic          i_ret = 1'b0;
  logic          i_flush = 1'b0;
  logic          o_push_en, o_pop_en, o_pred_valid, o_busy;
  logic [DW-1:0] o_push_data, o_pred_addr;
  logic [15:0]   o_ovf_cnt, o_unf_cnt;
  logic [DW-1:0] i_stk_pop_data;
  logic          i_stk_full, i_stk_empty;

  logic          s_push_en, s_pop_en, s_pred_valid, s_busy;
  logic [DW-1:0] s_push_data, s_pred_addr;
  logic [1:0]    s_ovf_cnt, s_unf_cnt;

  always #5 clk = ~clk;

  ras_ctrl #(.DW(DW), .ILEN(4), .CNTW(16)) u_dut (
    .clk(clk), .aresetn(aresetn), .i_call(i_call), .i_call_pc(i_call_pc),
    .i_ret(i_ret), .i_flush(i_flush), .o_push_en(o_push_en),
    .o_push_data(o_push_data), .o_pop_en(o_pop_en),
    .i_stk_pop_data(i_stk_pop_data), .i_stk_full(i_stk_full),
    .i_stk_empty(i_stk_empty), .o_pred_valid(o_pred_valid),
    .o_pred_addr(o_pred_addr), .o_busy(o_busy), .o_ovf_cnt(o_ovf_cnt),
    .o_unf_cnt(o_unf_cnt));

  // Narrow-counter instance sharing the same stimulus and stack view.
  ras_ctrl #(.DW(DW), .ILEN(4), .CNTW(2)) u_sat (
    .clk(clk), .aresetn(aresetn), .i_call(i_call), .i_call_pc(i_call_pc),
    .i_ret(i_ret), .i_flush(i_flush), .o_push_en(s_push_en),
    .o_push_data(s_push_data), .o_pop_en(s_pop_en),
    .i_stk_pop_data(i_stk_pop_data), .i_stk_full(i_stk_full),
    .i_stk_empty(i_stk_empty), .o_pred_valid(s_pred_valid),
    .o_pred_addr(s_pred_addr), .o_busy(s_busy), .o_ovf_cnt(s_ovf_cnt),
    .o_unf_cnt(s_unf_cnt));

  // Circular stack environment: push when full overwrites the oldest entry.
  logic [DW-1:0] mem [DPT];
  logic [2:0]    sp = 3'd0;
  logic [3:0]    cnt = 4'd0;

  assign i_stk_pop_data = mem[sp - 3'd1];
  assign i_stk_full     = (cnt == 4'(DPT));
  assign i_stk_empty    = (cnt == 4'd0);

  always @(posedge clk) begin
    if (o_push_en && o_pop_en) begin
      mem[sp - 3'd1] <= o_push_data;
    end else if (o_push_en) begin
      mem[sp] <= o_push_data;
      sp      <= sp + 3'd1;
      if (cnt != 4'(DPT)) cnt <= cnt + 4'd1;
    end else if (o_pop_en) begin
      sp  <= sp - 3'd1;
      cnt <= cnt - 4'd1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] ref_q[$];
  bit            ref_drain = 1'b0;
  int            ref_ovf = 0;
  int            ref_unf = 0;
  logic [DW-1:0] ref_paddr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic step(input bit c, input logic [DW-1:0] pc, input bit r, input bit f);
    bit e_push, e_pop, e_pl;
    @(negedge clk);
    i_call = c; i_call_pc = pc; i_ret = r; i_flush = f;
    #1;
    check("busy", 64'(o_busy), 64'(ref_drain));
    e_push = 1'b0; e_pop = 1'b0; e_pl = 1'b0;
    if (ref_drain) begin
      if (ref_q.size() != 0) begin
        e_pop = 1'b1;
        void'(ref_q.pop_back());
      end else begin
        ref_drain = 1'b0;
      end
    end else if (f) begin
      ref_drain = 1'b1;
    end else if (c && r) begin
      e_push = 1'b1;
      if (ref_q.size() != 0) begin
        e_pop = 1'b1; e_pl = 1'b1;
        ref_paddr = ref_q[ref_q.size()-1];
        ref_q[ref_q.size()-1] = pc + 32'd4;
      end else begin
        ref_unf++;
        ref_q.push_back(pc + 32'd4);
      end
    end else if (c) begin
      e_push = 1'b1;
      if (ref_q.size() == DPT) begin
        ref_ovf++;
        void'(ref_q.pop_front());
      end
      ref_q.push_back(pc + 32'd4);
    end else if (r) begin
      if (ref_q.size() != 0) begin
        e_pop = 1'b1; e_pl = 1'b1;
        ref_paddr = ref_q.pop_back();
      end else begin
        ref_unf++;
      end
    end
    check("push_en", 64'(o_push_en), 64'(e_push));
    check("pop_en", 64'(o_pop_en), 64'(e_pop));
    check("push_data", 64'(o_push_data), 64'(pc + 32'd4));
    @(posedge clk);
    #1;
    check("pred_valid", 64'(o_pred_valid), 64'(e_pl));
    check("pred_addr", 64'(o_pred_addr), 64'(ref_paddr));
    check("ovf_cnt", 64'(o_ovf_cnt), 64'(ref_ovf));
    check("unf_cnt", 64'(o_unf_cnt), 64'(ref_unf));
    check("sat_ovf", 64'(s_ovf_cnt), 64'(sat3(ref_ovf)));
    check("sat_unf", 64'(s_unf_cnt), 64'(sat3(ref_unf)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0; i_call = 1'b0; i_ret = 1'b0; i_flush = 1'b0;
    #1;
    check("rst_pop_en", 64'(o_pop_en), 64'd0);
    check("rst_push_en", 64'(o_push_en), 64'd0);
    @(posedge clk);
    #1;
    ref_drain = 1'b0; ref_ovf = 0; ref_unf = 0; ref_paddr = '0;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_pred_valid", 64'(o_pred_valid), 64'd0);
    check("rst_pred_addr", 64'(o_pred_addr), 64'd0);
    check("rst_ovf", 64'(o_ovf_cnt), 64'd0);
    check("rst_unf", 64'(o_unf_cnt), 64'd0);
    check("rst_sat_unf", 64'(s_unf_cnt), 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    int cyc;
    do_reset();

    // Three calls then three returns, LIFO order.
    step(1, 32'h100, 0, 0);
    step(1, 32'h200, 0, 0);
    step(1, 32'h300, 0, 0);
    step(0, 0, 1, 0); check("tp1_ret0", 64'(o_pred_addr), 64'h304);
    step(0, 0, 1, 0); check("tp1_ret1", 64'(o_pred_addr), 64'h204);
    step(0, 0, 1, 0); check("tp1_ret2", 64'(o_pred_addr), 64'h104);

    // Overflow: 10 calls into depth 8, then 9 returns.
    for (int n = 0; n < 10; n++) step(1, 32'h1000 + 32'(n) * 32'h10, 0, 0);
    check("tp2_ovf", 64'(o_ovf_cnt), 64'd2);
    step(0, 0, 1, 0); check("tp2_first", 64'(o_pred_addr), 64'h1094);
    for (int n = 1; n < 8; n++) step(0, 0, 1, 0);
    check("tp2_last", 64'(o_pred_addr), 64'h1024);
    step(0, 0, 1, 0);
    check("tp2_nopulse", 64'(o_pred_valid), 64'd0);
    check("tp2_unf", 64'(o_unf_cnt), 64'd1);

    // Coroutine swap with two entries.
    step(1, 32'h500, 0, 0);
    step(1, 32'h600, 0, 0);
    step(1, 32'h400, 1, 0); check("tp3_swap", 64'(o_pred_addr), 64'h604);
    step(0, 0, 1, 0);       check("tp3_ret0", 64'(o_pred_addr), 64'h404);
    step(0, 0, 1, 0);       check("tp3_ret1", 64'(o_pred_addr), 64'h504);

    // Flush with call asserted, ret during drain ignored.
    for (int n = 0; n < 5; n++) step(1, 32'h2000 + 32'(n) * 32'h8, 0, 0);
    step(1, 32'h3000, 0, 1);
    for (cyc = 1; cyc <= 6; cyc++) step(0, 0, (cyc == 3), 0);
    check("tp4_unf_kept", 64'(o_unf_cnt), 64'd1);
    check("tp4_run", 64'(o_busy), 64'd0);

    // Second flush mid-drain does not restart.
    for (int n = 0; n < 5; n++) step(1, 32'h4000 + 32'(n) * 32'h4, 0, 0);
    step(0, 0, 0, 1);
    for (cyc = 1; cyc <= 6; cyc++) step(0, 0, 0, (cyc == 3));
    check("tp5_run", 64'(o_busy), 64'd0);

    // Reset at drain cycle 2.
    for (int n = 0; n < 5; n++) step(1, 32'h5000 + 32'(n) * 32'h4, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    do_reset();

    // Drain leftovers, then saturate the narrow underflow counter.
    step(0, 0, 0, 1);
    for (cyc = 0; cyc < 12 && ref_drain; cyc++) step(0, 0, 0, 0);
    for (int n = 0; n < 5; n++) step(0, 0, 1, 0);
    check("tp6_sat", 64'(s_unf_cnt), 64'd3);
    check("tp6_wide", 64'(o_unf_cnt), 64'd5);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 2) == 0), {$urandom_range(0, 32'hFFFF), 2'b00},
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
- Controller for the return-address call stack (depth DPT, data DW) in the fetch/decode branch predictor.
- Turns decoded call/return events into stack push/pop strobes and computes the return address pushed on each call.
- Registers the predicted return target for the fetch PC mux.
- On pipeline flush, drains the stack to empty with a sequenced pop FSM, and keeps saturating overflow/underflow statistics.

Parameters:
- DW, 32, address/data width (matches stack DW).
- ILEN, 4, byte offset added to call PC to form the return address.
- CNTW, 16, width of the overflow/underflow statistic counters.

Ports:
- clk  in  1  clock
- aresetn  in  1  reset
- i_call  in  1  decode: call detected (JAL/JALR with rd=ra)
- i_call_pc  in  DW  PC of the call instruction
- i_ret  in  1  decode: return detected (JALR rs1=ra, rd!=ra)
- i_flush  in  1  mispredict/exception flush; invalidate stack
- o_push_en  out  1  to stack push enable
- o_push_data  out  DW  to stack push data
- o_pop_en  out  1  to stack pop enable
- i_stk_pop_data  in  DW  stack top-of-stack data (combinational read)
- i_stk_full  in  1  stack full flag
- i_stk_empty  in  1  stack empty flag
- o_pred_valid  out  1  registered one-cycle pulse: predicted return target valid
- o_pred_addr  out  DW  predicted return target
- o_busy  out  1  drain in progress; call/ret requests ignored
- o_ovf_cnt  out  CNTW  saturating count of pushes that overwrote the oldest entry
- o_unf_cnt  out  CNTW  saturating count of returns seen with stack empty

Behaviour:
- Clock and reset: one clock, clk. aresetn is synchronous, active-low, sampled on posedge clk.
- Reset values: state=RUN, o_pred_valid=0, o_pred_addr=0, o_busy=0, o_ovf_cnt=0, o_unf_cnt=0.
- Reset mid-drain aborts the drain immediately; stack contents are not touched by this block on reset.
- Stack strobes are combinational from the current state and inputs. Zero latency to the stack.
- o_push_data = i_call_pc + ILEN, modulo 2^DW, always driven.
- FSM states: RUN, DRAIN.

RUN state:
- i_flush=1: o_push_en=0, o_pop_en=0, call/ret dropped, next=DRAIN. Flush has priority over everything.
- Else i_call only: o_push_en=1.
  - o_ovf_cnt += 1 (saturating) if i_stk_full=1.
- Else i_ret only:
  - If !i_stk_empty: o_pop_en=1; next cycle o_pred_valid=1 and o_pred_addr = i_stk_pop_data sampled this cycle.
  - If i_stk_empty: o_pop_en=0, no prediction, o_unf_cnt += 1 (saturating).
- Else i_call and i_ret (coroutine swap):
  - If !i_stk_empty: o_push_en=1 and o_pop_en=1. The stack overwrites its top entry. Prediction = old top, registered as above. No ovf increment.
  - If i_stk_empty: push only, no prediction, o_unf_cnt += 1 (saturating). o_ovf_cnt is not incremented.
- o_pred_valid is a single-cycle pulse; o_pred_addr holds its last value otherwise.

DRAIN state:
- o_busy=1. All call/ret inputs are ignored and not counted.
- o_push_en=0; o_pop_en = !i_stk_empty (one pop per cycle).
- i_stk_empty=1 -> next=RUN (no pop that cycle).
- i_flush during DRAIN: stays in DRAIN, no restart.

Drain timing:
- Flush at cycle 0 with k entries: pops on cycles 1..k, empty seen on cycle k+1, RUN from cycle k+2.
- o_busy is high on cycles 1..k+1.
- Flush with the stack already empty: o_busy high for exactly 1 cycle.

Counters:
- Saturate at 2^CNTW-1 and never wrap.
- Both may change in the same cycle only if different events; they cannot, by construction.

Test Plan:
- Reset, then 3 calls at PC 0x100, 0x200, 0x300 -> pushes 0x104, 0x204, 0x304; then 3 rets -> o_pred_addr 0x304, 0x204, 0x104 on consecutive pulses, one cycle after each ret.
- DPT=8: 10 calls at PC 0x1000+0x10*n (n=0..9) -> o_ovf_cnt=2; 8 rets -> predictions 0x1094 down to 0x1024; 9th ret -> no pulse, o_unf_cnt=1.
- Stack holds 2 entries, assert i_call (PC 0x400) and i_ret together -> o_pred_addr = old top; next ret predicts 0x404; next ret predicts the older entry.
- 5 entries pushed, flush at cycle 0 with call asserted -> no push; o_pop_en on cycles 1..5, o_busy cycles 1..6; i_ret on cycle 3 ignored (o_unf_cnt unchanged); RUN at cycle 7.
- Second flush at drain cycle 3 -> drain continues without restart; aresetn low at drain cycle 2 -> next cycle RUN, o_busy=0, counters 0.
- CNTW=2, 5 returns on empty stack -> o_unf_cnt saturates at 3.
